pipe_hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core: the block that drives the ID/EX register's clear0 bubble mux and the IF and IF/ID write enables. It keeps its own three-entry destination scoreboard for the instructions in EX, MA and WB. Each cycle it compares that scoreboard with the source registers of the instruction in ID, and with the branch/jump outcome resolved in MA, then asserts stall or flush.

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/pipe_hazard_unit_if.sv | 34 +++
 rtl/hazard_decode.sv | 70 +++++++
 rtl/pipe_hazard_unit.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, the
// scoreboard entry type, the controller FSM states and a match helper.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // One in-flight producer: which register it will write and whether the
  // value only appears after the memory stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // True when a live scoreboard entry writes a register the ID instruction reads.
  function automatic logic sb_match(input sb_entry_t e,
                                    input logic rs_used, input logic [4:0] rs,
                                    input logic rt_used, input logic [4:0] rt);
    return e.valid && ((rs_used && (rs == e.dest)) || (rt_used && (rt == e.dest)));
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
// The dbg_* signals expose controller state for observation only.
interface pipe_hazard_unit_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [31:0]      inst_id;
  logic             id_valid;
  logic             branch_taken_ma;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_clear;
  logic             exma_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  state_t           dbg_state;
  sb_entry_t        dbg_ex;
  sb_entry_t        dbg_ma;
  sb_entry_t        dbg_wb;

  modport master (
    output inst_id, id_valid, branch_taken_ma,
    input  pc_we, ifid_we, ifid_flush, idex_clear, exma_flush,
    input  stall_cycles, flush_events, dbg_state, dbg_ex, dbg_ma, dbg_wb
  );

  modport slave (
    input  inst_id, id_valid, branch_taken_ma,
    output pc_we, ifid_we, ifid_flush, idex_clear, exma_flush,
    output stall_cycles, flush_events, dbg_state, dbg_ex, dbg_ma, dbg_wb
  );
endinterface

// File: rtl/hazard_decode.sv
// Combinational decode of the ID instruction into the registers it reads
// and the register it will write. Register 0 is filtered out on both sides.
module hazard_decode
  import pipe_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_src_rs_used,
  output logic        o_src_rt_used,
  output logic [4:0]  o_dest,
  output logic        o_dest_valid,
  output logic        o_is_load
);
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic        w_rs_used, w_rt_used, w_writes;
  logic        w_unused;

  assign w_op     = i_inst[31:26];
  assign w_rs     = i_inst[25:21];
  assign w_rt     = i_inst[20:16];
  assign w_rd     = i_inst[15:11];
  assign w_unused = ^i_inst[10:0];

  // Opcode table: sources read and destination written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    w_writes  = 1'b0;
    o_dest    = REG_ZERO;
    o_is_load = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
        w_writes  = 1'b1;
        o_dest    = w_rd;
      end
      OP_LW: begin
        w_rs_used = 1'b1;
        w_writes  = 1'b1;
        o_dest    = w_rt;
        o_is_load = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        w_rs_used = 1'b1;
        w_writes  = 1'b1;
        o_dest    = w_rt;
      end
      OP_LUI: begin
        w_writes = 1'b1;
        o_dest   = w_rt;
      end
      OP_JAL: begin
        w_writes = 1'b1;
        o_dest   = REG_RA;
      end
      default: ;
    endcase
  end

  assign o_src_rs_used = w_rs_used && (w_rs != REG_ZERO);
  assign o_src_rt_used = w_rt_used && (w_rt != REG_ZERO);
  assign o_dest_valid  = w_writes && (o_dest != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall/flush controller for the five-stage pipeline. Keeps an EX/MA/WB
// destination scoreboard and compares it with the ID sources each cycle.
// Build option: HAZARD_FORWARD_EN -- when defined only load-use hazards
// stall (forwarding exists downstream); otherwise any RAW hit in EX or MA stalls.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input logic               clk,
  input logic               rst,
  pipe_hazard_unit_if.slave bus
);
  sb_entry_t        r_ex, r_ma, r_wb, w_id_entry;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
  logic             w_rs_used, w_rt_used, w_dest_valid, w_is_load;
  logic [4:0]       w_dest, w_rs, w_rt;
  logic             w_match_ex, w_match_ma, w_haz_raw, w_haz, w_flush, w_stall;
  logic             w_pc_we, w_ifid_we, w_ifid_flush, w_idex_clear, w_exma_flush;

  hazard_decode u_decode (
    .i_inst        (bus.inst_id),
    .o_src_rs_used (w_rs_used),
    .o_src_rt_used (w_rt_used),
    .o_dest        (w_dest),
    .o_dest_valid  (w_dest_valid),
    .o_is_load     (w_is_load)
  );

  assign w_rs       = bus.inst_id[25:21];
  assign w_rt       = bus.inst_id[20:16];
  assign w_id_entry = '{valid: w_dest_valid, dest: w_dest, is_load: w_is_load};
  assign w_match_ex = sb_match(r_ex, w_rs_used, w_rs, w_rt_used, w_rt);
  assign w_match_ma = sb_match(r_ma, w_rs_used, w_rs, w_rt_used, w_rt);

`ifdef HAZARD_FORWARD_EN
  assign w_haz_raw = w_match_ex && r_ex.is_load;
`else
  assign w_haz_raw = w_match_ex || w_match_ma;
`endif

  // A bubble in ID has no sources, so it can never be held back.
  assign w_haz   = bus.id_valid && w_haz_raw;
  assign w_flush = bus.branch_taken_ma;
  assign w_stall = w_haz && !w_flush;

  // Mealy control outputs: reset hold, then flush over stall over run.
  always_comb begin
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_clear = 1'b0;
    w_exma_flush = 1'b0;
    if (!rst) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_clear = 1'b1;
    end else if (w_flush) begin
      w_ifid_flush = 1'b1;
      w_idex_clear = 1'b1;
      w_exma_flush = 1'b1;
    end else if (w_haz) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_clear = 1'b1;
    end
  end

  // FSM next state: stay stalled only while an unflushed hazard persists.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_stall) w_state_nxt = ST_STALL;
      ST_STALL: if (!w_haz || w_flush) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // Scoreboard shift EX->MA->WB; squashed or bubble slots enter as invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex <= '0;
      r_ma <= '0;
      r_wb <= '0;
    end else begin
      r_wb <= r_ma;
      r_ma <= w_exma_flush ? '0 : r_ex;
      r_ex <= (w_idex_clear || !bus.id_valid) ? '0 : w_id_entry;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush && (r_flush_events != '1)) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign bus.pc_we        = w_pc_we;
  assign bus.ifid_we      = w_ifid_we;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_clear   = w_idex_clear;
  assign bus.exma_flush   = w_exma_flush;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_ex       = r_ex;
  assign bus.dbg_ma       = r_ma;
  assign bus.dbg_wb       = r_wb;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: each step drives ID/branch inputs at
// the falling edge, queues the expected controls and counters, and compares
// them shortly after. Expectations follow the HAZARD_FORWARD_EN setting.
module tb_pipe_hazard_unit;
  import pipe_pkg::*;

  localparam logic [4:0] C_RUN   = 5'b11000; // {pc_we,ifid_we,ifid_flush,idex_clear,exma_flush}
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_RST   = 5'b00010;
`ifdef HAZARD_FORWARD_EN
  localparam logic [4:0] C_NF    = C_RUN;
`else
  localparam logic [4:0] C_NF    = C_STALL;
`endif

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd2, 16'h0000};         // lw  $2,0($1)
  localparam logic [31:0] I_ADD3 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20}; // add $3,$2,$4
  localparam logic [31:0] I_ADD2 = {6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20}; // add $2,$1,$1
  localparam logic [31:0] I_SUB5 = {6'h00, 5'd2, 5'd3, 5'd5, 5'd0, 6'h22}; // sub $5,$2,$3
  localparam logic [31:0] I_ADD0 = {6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 6'h20}; // add $0,$1,$1
  localparam logic [31:0] I_ADD4 = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20}; // add $4,$0,$0

  typedef struct {
    string       tag;
    logic [4:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sc = 16'h0;
  logic [15:0] exp_fe = 16'h0;
  exp_t        sb_q[$];

  pipe_hazard_unit_if #(.CNT_W(16)) bus ();

  pipe_hazard_unit #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the current cycle, then compare the DUT against it.
  task automatic expect_now(input string tag, input logic [4:0] ctrl);
    exp_t e;
    logic [4:0] obs;
    sb_q.push_back('{tag: tag, ctrl: ctrl, sc: exp_sc, fe: exp_fe});
    #1;
    e   = sb_q.pop_front();
    obs = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_clear, bus.exma_flush};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed %b expected %b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (bus.stall_cycles === e.sc) else begin
      errors++;
      $error("FAIL %s stall_cycles observed %h expected %h", e.tag, bus.stall_cycles, e.sc);
    end
    checks++;
    assert (bus.flush_events === e.fe) else begin
      errors++;
      $error("FAIL %s flush_events observed %h expected %h", e.tag, bus.flush_events, e.fe);
    end
    if (rst) begin
      if (ctrl == C_STALL) exp_sc = sat_inc(exp_sc);
      if (ctrl == C_FLUSH) exp_fe = sat_inc(exp_fe);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] inst, input logic valid,
                      input logic br, input logic [4:0] ctrl);
    @(negedge clk);
    bus.inst_id         = inst;
    bus.id_valid        = valid;
    bus.branch_taken_ma = br;
    expect_now(tag, ctrl);
  endtask

  initial begin
    bus.inst_id         = I_NOP;
    bus.id_valid        = 1'b0;
    bus.branch_taken_ma = 1'b0;

    // Reset state
    step("reset_hold", I_NOP, 1'b0, 1'b0, C_RST);
    check_bit("reset_state_run", bus.dbg_state == ST_STALL, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Load-use: lw $2 then add $3,$2,$4
    step("lu_lw",    I_LW,   1'b1, 1'b0, C_RUN);
    step("lu_use",   I_ADD3, 1'b1, 1'b0, C_STALL);
    check_bit("lu_state_stall", bus.dbg_state == ST_STALL, 1'b0);
    step("lu_use2",  I_ADD3, 1'b1, 1'b0, C_NF);
    check_bit("lu_state_after", bus.dbg_state == ST_STALL, 1'b1);
    step("lu_done",  I_ADD3, 1'b1, 1'b0, C_RUN);
    step("nop_a1",   I_NOP,  1'b0, 1'b0, C_RUN);
    step("nop_a2",   I_NOP,  1'b0, 1'b0, C_RUN);

    // ALU RAW: add $2 then sub $5,$2,$3
    step("raw_add",  I_ADD2, 1'b1, 1'b0, C_RUN);
    step("raw_sub1", I_SUB5, 1'b1, 1'b0, C_NF);
    step("raw_sub2", I_SUB5, 1'b1, 1'b0, C_NF);
    step("raw_done", I_SUB5, 1'b1, 1'b0, C_RUN);
    step("nop_b1",   I_NOP,  1'b0, 1'b0, C_RUN);
    step("nop_b2",   I_NOP,  1'b0, 1'b0, C_RUN);

    // Register 0 never forms a hazard
    step("r0_write", I_ADD0, 1'b1, 1'b0, C_RUN);
    step("r0_read",  I_ADD4, 1'b1, 1'b0, C_RUN);
    check_bit("r0_ex_invalid", bus.dbg_ex.valid, 1'b0);
    step("nop_c1",   I_NOP,  1'b0, 1'b0, C_RUN);
    step("nop_c2",   I_NOP,  1'b0, 1'b0, C_RUN);

    // Flush wins over a same-cycle load-use hazard
    step("fl_lw",    I_LW,   1'b1, 1'b0, C_RUN);
    step("fl_flush", I_ADD3, 1'b1, 1'b1, C_FLUSH);
    step("fl_after", I_NOP,  1'b0, 1'b0, C_RUN);
    check_bit("fl_ex_invalid", bus.dbg_ex.valid, 1'b0);
    check_bit("fl_ma_invalid", bus.dbg_ma.valid, 1'b0);
    check_bit("fl_state_run",  bus.dbg_state == ST_STALL, 1'b0);
    step("nop_d1",   I_NOP,  1'b0, 1'b0, C_RUN);

    // Reset pulsed during the first stall cycle
    step("rs_lw",    I_LW,   1'b1, 1'b0, C_RUN);
    step("rs_stall", I_ADD3, 1'b1, 1'b0, C_STALL);
    #1 rst = 1'b0;
    exp_sc = 16'h0;
    exp_fe = 16'h0;
    expect_now("rs_mid_stall", C_RST);
    @(posedge clk);
    #1 rst = 1'b1;
    step("rs_release", I_ADD3, 1'b1, 1'b0, C_RUN);
    check_bit("rs_ex_empty",  bus.dbg_ex.valid, 1'b0);
    check_bit("rs_state_run", bus.dbg_state == ST_STALL, 1'b0);
    step("nop_e1",   I_NOP,  1'b0, 1'b0, C_RUN);
    step("nop_e2",   I_NOP,  1'b0, 1'b0, C_RUN);

    // Stall counter saturation from 16'hFFFE
    @(negedge clk);
    force dut.r_stall_cycles = 16'hFFFE;
    #1 release dut.r_stall_cycles;
    exp_sc = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      step("sat_lw",    I_LW,   1'b1, 1'b0, C_RUN);
      step("sat_stall", I_ADD3, 1'b1, 1'b0, C_STALL);
      step("sat_next",  I_ADD3, 1'b1, 1'b0, C_NF);
      step("sat_nop",   I_NOP,  1'b0, 1'b0, C_RUN);
    end
    step("sat_hold", I_NOP, 1'b0, 1'b0, C_RUN);
    check_bit("sat_all_ones", bus.stall_cycles == 16'hFFFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
